// File: rtl/branch_resolve_if.sv
// Decode lookup, execute resolve, and fetch redirect/perf signals of the branch resolver.
// master drives the lookup PC and resolve info; slave is the resolver itself.
interface branch_resolve_if;
    logic [31:0] lk_pc;
    logic        lk_taken;
    logic        init_busy;
    logic        rs_valid;
    logic        rs_is_branch;
    logic        rs_is_jump;
    logic [31:0] rs_pc;
    logic [31:0] rs_target;
    logic        rs_pred_taken;
    logic        rs_actual_taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    modport master (
        output lk_pc, rs_valid, rs_is_branch, rs_is_jump, rs_pc, rs_target,
               rs_pred_taken, rs_actual_taken,
        input  lk_taken, init_busy, flush, redirect_pc, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  lk_pc, rs_valid, rs_is_branch, rs_is_jump, rs_pc, rs_target,
               rs_pred_taken, rs_actual_taken,
        output lk_taken, init_busy, flush, redirect_pc, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// Bimodal BHT with branch resolution, registered flush/redirect on mispredict,
// and branch/mispredict perf counters. The BHT is swept to CNT_INIT after reset.
module branch_resolve #(
    parameter int         BHT_ENTRIES  = 64,
    parameter logic [1:0] CNT_INIT     = 2'b01,
    parameter int         FLUSH_CYCLES = 2
) (
    input logic              clk,
    input logic              reset,
    branch_resolve_if.slave  br
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              flush_q, flush_d;
    logic [31:0]       redirect_q, redirect_d;
    logic [31:0]       branch_cnt_q, branch_cnt_d;
    logic [31:0]       mis_cnt_q, mis_cnt_d;
    logic [1:0]        bht_q [BHT_ENTRIES];
    logic [1:0]        bht_d [BHT_ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  rs_idx;
    logic [1:0]        cur_cnt;

    assign lk_idx = br.lk_pc[IDX_W+1:2];
    assign rs_idx = br.rs_pc[IDX_W+1:2];

    // Lookup reads the registered table, so a same-cycle update is not yet visible.
    assign br.lk_taken       = (state_q != ST_INIT) && bht_q[lk_idx][1];
    assign br.init_busy      = (state_q == ST_INIT);
    assign br.flush          = flush_q;
    assign br.redirect_pc    = redirect_q;
    assign br.branch_cnt     = branch_cnt_q;
    assign br.mispredict_cnt = mis_cnt_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fcnt_d       = fcnt_q;
        flush_d      = 1'b0;
        redirect_d   = redirect_q;
        branch_cnt_d = branch_cnt_q;
        mis_cnt_d    = mis_cnt_q;
        bht_d        = bht_q;
        cur_cnt      = bht_q[rs_idx];

        case (state_q)
            ST_INIT: begin
                bht_d[idx_q] = CNT_INIT;
                idx_d        = idx_q + 1'b1;
                if (idx_q == IDX_W'(BHT_ENTRIES - 1)) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                // A branch flag wins over a jump flag; jump-only is redirected by decode.
                if (br.rs_valid && br.rs_is_branch) begin
                    branch_cnt_d = branch_cnt_q + 32'd1;
                    if (br.rs_actual_taken) begin
                        if (cur_cnt != 2'b11) bht_d[rs_idx] = cur_cnt + 2'b01;
                    end else begin
                        if (cur_cnt != 2'b00) bht_d[rs_idx] = cur_cnt - 2'b01;
                    end
                    if (br.rs_pred_taken != br.rs_actual_taken) begin
                        mis_cnt_d  = mis_cnt_q + 32'd1;
                        redirect_d = br.rs_actual_taken ? br.rs_target : br.rs_pc + 32'd4;
                        flush_d    = 1'b1;
                        fcnt_d     = FC_W'(FLUSH_CYCLES - 1);
                        state_d    = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d  = fcnt_q - 1'b1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            idx_q        <= '0;
            fcnt_q       <= '0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fcnt_q       <= fcnt_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            branch_cnt_q <= branch_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

    // Table contents need no reset value; the INIT sweep rewrites every entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bht_q <= bht_d;
        end
    end
endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed scenarios then randomized traffic,
// checked against a counter-table model; a negedge monitor matches flush redirects.
module tb_branch_resolve;
    localparam int         BHT_ENTRIES  = 64;
    localparam logic [1:0] CNT_INIT     = 2'b01;
    localparam int         FLUSH_CYCLES = 2;

    logic clk;
    logic reset;
    branch_resolve_if br();

    branch_resolve #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CNT_INIT    (CNT_INIT),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .br   (br.slave)
    );

    int checks = 0;
    int errors = 0;

    int          model_bht [BHT_ENTRIES];
    logic [31:0] model_branch;
    logic [31:0] model_mis;
    int          init_left;
    int          flush_left;
    logic [31:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int tbl_idx(input logic [31:0] pc);
        return int'((pc >> 2) % BHT_ENTRIES);
    endfunction

    function automatic logic model_pred(input logic [31:0] pc);
        return (init_left == 0) && (model_bht[tbl_idx(pc)] >= 2);
    endfunction

    // Advance one clock: model consumes the inputs currently driven, then outputs are checked.
    task automatic tick();
        int i;
        if (reset) begin
            init_left    = BHT_ENTRIES;
            flush_left   = 0;
            model_branch = 0;
            model_mis    = 0;
        end else if (init_left > 0) begin
            init_left--;
            if (init_left == 0)
                for (int k = 0; k < BHT_ENTRIES; k++) model_bht[k] = int'(CNT_INIT);
        end else if (flush_left > 0) begin
            flush_left--;
        end else if (br.rs_valid && br.rs_is_branch) begin
            model_branch++;
            i = tbl_idx(br.rs_pc);
            if (br.rs_actual_taken) model_bht[i] = (model_bht[i] < 3) ? model_bht[i] + 1 : 3;
            else                    model_bht[i] = (model_bht[i] > 0) ? model_bht[i] - 1 : 0;
            if (br.rs_pred_taken != br.rs_actual_taken) begin
                model_mis++;
                exp_q.push_back(br.rs_actual_taken ? br.rs_target : br.rs_pc + 32'd4);
                flush_left = FLUSH_CYCLES;
            end
        end
        @(posedge clk);
        #1;
        check_output("init_busy", {31'd0, br.init_busy}, {31'd0, init_left > 0});
        check_output("flush", {31'd0, br.flush}, {31'd0, flush_left > 0});
        check_output("branch_cnt", br.branch_cnt, model_branch);
        check_output("mispredict_cnt", br.mispredict_cnt, model_mis);
    endtask

    task automatic check_lookup(input logic [31:0] pc);
        br.lk_pc = pc;
        #1;
        check_output("lk_taken", {31'd0, br.lk_taken}, {31'd0, model_pred(pc)});
    endtask

    task automatic set_rs(input logic v, input logic isb, input logic isj, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pred, input logic act);
        br.rs_valid        = v;
        br.rs_is_branch    = isb;
        br.rs_is_jump      = isj;
        br.rs_pc           = pc;
        br.rs_target       = tgt;
        br.rs_pred_taken   = pred;
        br.rs_actual_taken = act;
    endtask

    task automatic apply_stimulus(input logic v, input logic isb, input logic isj,
                                  input logic [31:0] pc, input logic [31:0] tgt,
                                  input logic pred, input logic act);
        set_rs(v, isb, isj, pc, tgt, pred, act);
        tick();
        br.rs_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Scoreboard side: each flush rising edge pops one expected redirect; it must stay put while held.
    logic        prev_flush = 1'b0;
    logic [31:0] cur_exp = '0;
    always @(negedge clk) begin
        if (br.flush === 1'b1 && !prev_flush) begin
            if (exp_q.size() == 0) begin
                check_output("flush_unexpected", {31'd0, br.flush}, 32'd0);
            end else begin
                cur_exp = exp_q.pop_front();
                check_output("redirect_pc", br.redirect_pc, cur_exp);
            end
        end else if (br.flush === 1'b1) begin
            check_output("redirect_hold", br.redirect_pc, cur_exp);
        end
        prev_flush = (br.flush === 1'b1);
    end

    logic [31:0] pc_pool [8] = '{32'h0, 32'h40, 32'h100, 32'h200, 32'h1FC,
                                 32'hFFFF_FFFC, 32'h0000_1100, 32'h8000_0040};

    initial begin
        logic [31:0] pc, tgt;
        logic        v, isb, isj, pred, act;
        reset = 1'b0;
        br.lk_pc = '0;
        set_rs(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < BHT_ENTRIES; k++) model_bht[k] = 0;
        init_left = BHT_ENTRIES;
        flush_left = 0;
        model_branch = 0;
        model_mis = 0;
        @(posedge clk);
        #1;

        // Reset, INIT sweep with lookups forced low and resolves ignored.
        do_reset();
        check_lookup(32'h0);
        check_lookup(32'h4);
        check_lookup(32'hFC);
        for (int k = 0; k < 10; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h120, 1'b0, 1'b1);
        idle(BHT_ENTRIES - 11);
        check_lookup(32'h0);
        idle(1);
        check_lookup(32'h0);

        // Taken mispredict, then not-taken mispredict with an ignored branch in the flush window.
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h120, 1'b0, 1'b1);
        check_lookup(32'h100);
        idle(2);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h120, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h200, 32'h300, 1'b0, 1'b1);
        idle(2);
        check_lookup(32'h100);

        // Saturation at 3 and hysteresis back down.
        for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h80, model_pred(32'h40), 1'b1);
        idle(2);
        check_lookup(32'h40);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h80, 1'b1, 1'b0);
        idle(2);
        check_lookup(32'h40);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h80, 1'b1, 1'b0);
        idle(2);
        check_lookup(32'h40);

        // Aliasing, then a lookup that coincides with an update of its own entry.
        for (int k = 0; k < 2; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h180, 1'b1, 1'b1);
        check_lookup(32'h200);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h180, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h180, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h180, 1'b0, 1'b1);
        idle(2);
        set_rs(1'b1, 1'b1, 1'b0, 32'h100, 32'h180, 1'b0, 1'b0);
        set_rs(1'b1, 1'b1, 1'b0, 32'h100, 32'h180, 1'b1, 1'b1);
        check_lookup(32'h100);
        tick();
        br.rs_valid = 1'b0;
        check_lookup(32'h100);

        // Reset in the second flush cycle, pc+4 wrap, then jump-only resolves.
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0);
        idle(1);
        do_reset();
        idle(BHT_ENTRIES);
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h40, 32'h400, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h40, 32'h400, 1'b0, 1'b1);
        idle(3);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                pc   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc_pool[$urandom_range(0, 7)];
                tgt  = $urandom & 32'hFFFF_FFFC;
                v    = ($urandom_range(0, 9) < 7);
                isb  = ($urandom_range(0, 9) < 8);
                isj  = ($urandom_range(0, 9) < 2);
                act  = $urandom_range(0, 1) == 1;
                pred = ($urandom_range(0, 1) == 1) ? model_pred(pc) : ($urandom_range(0, 1) == 1);
                check_lookup(pc_pool[$urandom_range(0, 7)]);
                apply_stimulus(v, isb, isj, pc, tgt, pred, act);
            end
        end

        idle(FLUSH_CYCLES + 2);
        check_output("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
